gf256_inv_pipe: RTL and testbench
=================================

# gf256_inv_pipe

Pipelined, multi-lane GF(2^8) inverter built on a GF(2^4) tower field. Each accepted word carries LANES bytes, and every byte is inverted independently. The block sits on the HEA S-box datapath between the state register and the affine/mix stages. It replaces per-byte combinational inversion with a registered 3-stage pipeline: a valid/ready handshake, full back-pressure, a per-lane bypass and a zero flag.

## Interface
- LANES, default 4: bytes per word; legal range 1..16.
- TAG_W, default 4: width of the sideband tag carried alongside each word; legal range 1..16.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; clears all pipeline valid bits.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  8*LANES  byte i is in_data[8i+7:8i].
- in_bypass  in  LANES  bit i=1: byte i passes through unchanged.
- in_tag  in  TAG_W  sideband; returned unchanged with the result.
- out_valid  out  1  result word present.
- out_ready  in  1  downstream accepts.
- out_data  out  8*LANES  inverted (or bypassed) bytes.
- out_zero  out  LANES  bit i=1: input byte i was 8'h00 and not bypassed.
- out_tag  out  TAG_W  tag of the word now on out_data.

## Operation
- GF(2^4) arithmetic uses p(x)=x^4+x+1.
  - Multiplication is polynomial mod p.
  - Inverse table, index→value: 0→0, 1→1, 2→9, 3→E, 4→D, 5→B, 6→7, 7→6, 8→F, 9→2, A→C, B→5, C→A, D→4, E→3, F→8.
- Byte representation: b = {h,l} represents h·y+l in GF(2^4)[y]/(y^2+y+λ), with λ=4'h8.
- Inverse of a byte:
  - Δ = λ·h² ⊕ h·l ⊕ l².
  - Result = {h·Δ⁻¹, (h⊕l)·Δ⁻¹}.
  - 8'h00 maps to 8'h00 and sets out_zero.
- Bypass: a lane with bypass=1 outputs its input byte unchanged, and its out_zero is 0.
- Pipeline stages, each with its own valid bit, data, bypass and tag registers:
  - S1 registers h, l and Δ for every lane.
  - S2 registers Δ⁻¹ (table lookup) plus h and l.
  - S3 registers the final bytes and zero flags; S3 drives the outputs.
- Stage advance rule:
  - adv3 = out_ready | !v3.
  - adv2 = adv3 | !v2.
  - adv1 = adv2 | !v1.
  - in_ready = adv1.
- A stage whose advance signal is low holds all of its registers.
- The ready chain is combinational from out_ready to in_ready. No stage drops or duplicates a word.
- A handshake occurs on in_valid & in_ready, and on out_valid & out_ready.
- Data, bypass and tag values are captured only on a handshake or an internal advance. Registers of invalid stages are don't-care, except that out_data, out_zero and out_tag read 0 while out_valid=0.

## Timing
- Latency is exactly 3 cycles from input handshake to out_valid, with no stall.
- Throughput is 1 word/cycle while out_ready=1.
- Reset (rst_n=0, asynchronous):
  - All valid bits clear.
  - out_valid=0; out_data, out_zero and out_tag are 0.
  - in_ready=1 once reset is released.
- flush=1 clears v1, v2 and v3 at the next edge.
  - An input presented in the same cycle is discarded, even if in_ready=1.
  - flush takes priority over every handshake.
- out_valid, once asserted, stays asserted with stable out_data and out_tag until out_ready=1, except under flush or reset.
- Pipeline full with out_ready=0: in_ready=0 in the same cycle.
- Full pipeline with out_ready=1: a simultaneous input and output handshake keeps all stages full.
- rst_n asserted mid-stream: every in-flight word is lost, and nothing appears on the outputs after release.

## Test plan
- Known values, LANES=4, no bypass:
  - Stimulus: in_data=32'h00_10_02_01.
  - Required: 3 cycles later, out_data=32'h00_FF_09_01 and out_zero=4'b1000.
- Exhaustive inverse:
  - Stimulus: stream all 256 byte values.
  - Required: each nonzero result satisfies b·inv(b)=8'h01 in the tower field, and 8'h00 maps to 8'h00.
- Bypass:
  - Stimulus: in_data=32'h00_10_02_01, in_bypass=4'b1001.
  - Required: out_data=32'h00_FF_09_01 and out_zero=4'b0000.
- Back-pressure:
  - Stimulus: 10 back-to-back words with tags 0..9, while out_ready toggles randomly.
  - Required:
    - Tags emerge in order, with no loss or duplication.
    - out_data is stable while out_valid=1 and out_ready=0.
    - in_ready drops after 3 words are held.
- Flush:
  - Stimulus: fill the pipeline with out_ready=0, then pulse flush together with in_valid=1.
  - Required: next cycle out_valid=0 and in_ready=1; no flushed tag ever appears.
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-stream.
  - Required: outputs are 0 immediately; after release, out_valid stays 0 until 3 cycles after a new input handshake.

Source files
------------

// File: rtl/gf256_inv_pipe.sv
// gf256_inv_pipe: 3-stage, multi-lane GF(2^8) inverter over a GF(2^4) tower field.
// Each byte {h,l} stands for h*y + l in GF(2^4)[y]/(y^2 + y + lambda), with
// GF(2^4) = GF(2)[x]/(x^4 + x + 1). Valid/ready handshake with full back-pressure,
// a per-lane bypass, a zero flag per lane and a sideband tag carried with each word.
module gf256_inv_pipe #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [LANES-1:0]     in_bypass,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [LANES-1:0]     out_zero,
  output logic [TAG_W-1:0]     out_tag
);

  localparam logic [3:0] LAMBDA = 4'h8;

  // Shift-and-add multiply in GF(2^4); x^4 folds back to x + 1.
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = '0;
    sh  = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // Multiplicative inverse in GF(2^4); 0 maps to 0 so a zero byte yields 0.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h0: r = 4'h0;  4'h1: r = 4'h1;  4'h2: r = 4'h9;  4'h3: r = 4'hE;
      4'h4: r = 4'hD;  4'h5: r = 4'hB;  4'h6: r = 4'h7;  4'h7: r = 4'h6;
      4'h8: r = 4'hF;  4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h5;
      4'hC: r = 4'hA;  4'hD: r = 4'h4;  4'hE: r = 4'h3;  default: r = 4'h8;
    endcase
    return r;
  endfunction

  // Stage valid bits and the combinational ready chain from the output back.
  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  assign adv3     = out_ready | ~v3;
  assign adv2     = adv3 | ~v2;
  assign adv1     = adv2 | ~v1;
  assign in_ready = adv1;

  // Stage registers.
  logic [LANES-1:0][3:0] h1, l1, d1;
  logic [LANES-1:0][3:0] h2, l2, dinv2;
  logic [LANES-1:0]      byp1, byp2, zero3;
  logic [TAG_W-1:0]      tag1, tag2, tag3;
  logic [8*LANES-1:0]    data3;

  // Next-stage values.
  logic [LANES-1:0][3:0] h_in, l_in, d_in, dinv_nxt;
  logic [8*LANES-1:0]    data_nxt;
  logic [LANES-1:0]      zero_nxt;

  // S1 input: split each byte into nibbles and form delta = lambda*h^2 + h*l + l^2.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // first, so no path through the block leaves a value held (no latch).
    h_in = '0;
    l_in = '0;
    d_in = '0;
    for (int i = 0; i < LANES; i++) begin
      h_in[i] = in_data[8*i+4 +: 4];
      l_in[i] = in_data[8*i +: 4];
      d_in[i] = gf16_mul(LAMBDA, gf16_mul(h_in[i], h_in[i]))
              ^ gf16_mul(h_in[i], l_in[i])
              ^ gf16_mul(l_in[i], l_in[i]);
    end
  end

  // S2 input: invert delta through the GF(2^4) table.
  always_comb begin
    dinv_nxt = '0;
    for (int i = 0; i < LANES; i++) dinv_nxt[i] = gf16_inv(d1[i]);
  end

  // S3 input: result = {h*dinv, (h^l)*dinv}, or the raw byte on bypassed lanes.
  always_comb begin
    data_nxt = '0;
    zero_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (byp2[i]) begin
        data_nxt[8*i +: 8] = {h2[i], l2[i]};
      end else begin
        data_nxt[8*i +: 8] = {gf16_mul(h2[i], dinv2[i]), gf16_mul(h2[i] ^ l2[i], dinv2[i])};
      end
      zero_nxt[i] = ~byp2[i] & ({h2[i], l2[i]} == 8'h00);
    end
  end

  // Valid bits: flush wins over every advance; a stalled stage keeps its bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
    end
  end

  // Datapath registers load only when a valid word moves into the stage.
  // NOTE: these carry no reset; their contents are meaningless while the stage's
  // valid bit is clear, and the outputs are gated by v3 below.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      h1   <= h_in;
      l1   <= l_in;
      d1   <= d_in;
      byp1 <= in_bypass;
      tag1 <= in_tag;
    end
    if (adv2 && v1) begin
      h2    <= h1;
      l2    <= l1;
      dinv2 <= dinv_nxt;
      byp2  <= byp1;
      tag2  <= tag1;
    end
    if (adv3 && v2) begin
      data3 <= data_nxt;
      zero3 <= zero_nxt;
      tag3  <= tag2;
    end
  end

  assign out_valid = v3;
  assign out_data  = v3 ? data3 : '0;
  assign out_zero  = v3 ? zero3 : '0;
  assign out_tag   = v3 ? tag3  : '0;

endmodule

// File: tb/tb_gf256_inv_pipe.sv
// tb_gf256_inv_pipe: directed stimulus for gf256_inv_pipe with a scoreboard whose
// expected bytes come from a brute-force search for b*x = 1 in the tower field.
module tb_gf256_inv_pipe;

  localparam logic [3:0] LAM = 4'h8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_bypass;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_zero;
  logic [3:0]  out_tag;

  gf256_inv_pipe #(.LANES(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bypass(in_bypass), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int out_hs   = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  zero;
    logic [3:0]  tag;
    int          ent;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  inv_tab[256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // GF(2^4): carry-less product, then reduce by x^4 + x + 1.
  function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
    for (int k = 6; k >= 4; k--) if (p[k]) p = p ^ (7'b0010011 << (k - 4));
    return p[3:0];
  endfunction

  // Tower-field product (ah*y + al)(bh*y + bl) with y^2 = y + lambda.
  function automatic logic [7:0] t_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh, yc, c0;
    hh = m_mul(a[7:4], b[7:4]);
    yc = hh ^ m_mul(a[7:4], b[3:0]) ^ m_mul(a[3:0], b[7:4]);
    c0 = m_mul(LAM, hh) ^ m_mul(a[3:0], b[3:0]);
    return {yc, c0};
  endfunction

  function automatic exp_t model(input logic [31:0] d, input logic [3:0] byp,
                                 input logic [3:0] tag);
    exp_t r;
    logic [7:0] b;
    r.data = '0;
    r.zero = '0;
    r.tag  = tag;
    r.ent  = 0;
    for (int i = 0; i < 4; i++) begin
      b = d[8*i +: 8];
      r.data[8*i +: 8] = byp[i] ? b : inv_tab[b];
      r.zero[i]        = !byp[i] && (b == 8'h00);
    end
    return r;
  endfunction

  // Scoreboard and per-cycle compare, sampled on the falling edge.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_tag;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      exp_v = (sb.size() > 0) && (cyc - sb[0].ent >= 3);
      check("out_valid", 64'(out_valid), 64'(exp_v));
      check("in_ready", 64'(in_ready), 64'(!(sb.size() >= 3 && !out_ready)));
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("out_extra", 64'(out_valid), 64'(0));
        end else begin
          check("out_data", 64'(out_data), 64'(sb[0].data));
          check("out_zero", 64'(out_zero), 64'(sb[0].zero));
          check("out_tag",  64'(out_tag),  64'(sb[0].tag));
        end
        if (prev_stall) begin
          check("hold_data", 64'(out_data), 64'(prev_data));
          check("hold_tag",  64'(out_tag),  64'(prev_tag));
        end
      end else begin
        check("idle_zero", 64'({out_data, out_zero, out_tag}), 64'(0));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
      if (flush) begin
        sb.delete();
        prev_stall = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          out_hs++;
          if (sb.size() > 0) void'(sb.pop_front());
        end
        if (in_valid && in_ready) begin
          e     = model(in_data, in_bypass, in_tag);
          e.ent = cyc;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int mode, input int idx);
    if (mode == 0) return {8'(4*idx+3), 8'(4*idx+2), 8'(4*idx+1), 8'(4*idx)};
    return 32'(idx + 1) * 32'h9E3779B1;
  endfunction

  // Present n words back to back; each is held until accepted.
  task automatic send_words(input int n, input int tag0, input int mode, input bit rand_ready);
    int sent  = 0;
    int guard = 0;
    while (sent < n && guard < 1000) begin
      in_valid  = 1'b1;
      in_data   = word_of(mode, tag0 + sent);
      in_tag    = 4'(tag0 + sent);
      in_bypass = 4'b0000;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) sent++;
      step();
      guard++;
    end
    in_valid = 1'b0;
    check("send_done", 64'(sent), 64'(n));
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1'b1;
    while (sb.size() > 0 && g < 50) begin
      step();
      g++;
    end
    step();
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  // Single word with an exact 3-cycle latency check against literal values.
  task automatic known_vec(input logic [3:0] byp, input logic [3:0] exp_zero,
                           input logic [3:0] tag, input string name);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h00_10_02_01;
    in_bypass = byp;
    in_tag    = tag;
    step();
    in_valid = 1'b0;
    step();
    check({name, "_early"}, 64'(out_valid), 64'(0));
    step();
    check({name, "_valid"}, 64'(out_valid), 64'(1));
    check({name, "_data"},  64'(out_data),  64'(32'h00_FF_09_01));
    check({name, "_zero"},  64'(out_zero),  64'(exp_zero));
    check({name, "_tag"},   64'(out_tag),   64'(tag));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int hs0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_bypass = '0; in_tag = '0; out_ready = 1'b0;

    // Build the model inverse table by exhaustive search.
    for (int b = 0; b < 256; b++) begin
      inv_tab[b] = 8'h00;
      for (int x = 1; x < 256; x++)
        if (b != 0 && t_mul(8'(b), 8'(x)) == 8'h01) inv_tab[b] = 8'(x);
    end
    check("pin_gf16_2x9", 64'(m_mul(4'h2, 4'h9)), 64'h1);
    check("pin_inv_10",   64'(inv_tab[8'h10]), 64'hFF);
    check("pin_inv_02",   64'(inv_tab[8'h02]), 64'h09);
    check("pin_inv_01",   64'(inv_tab[8'h01]), 64'h01);
    check("pin_inv_00",   64'(inv_tab[8'h00]), 64'h00);

    // Reset state.
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs",   64'({out_data, out_zero, out_tag}), 64'(0));
    check("rst_in_ready",  64'(in_ready), 64'(1));
    step();

    // Known values, then bypass on lanes 0 and 3.
    known_vec(4'b0000, 4'b1000, 4'h5, "known");
    known_vec(4'b1001, 4'b0000, 4'h6, "bypass");

    // All 256 byte values, four per word.
    out_ready = 1'b1;
    send_words(64, 0, 0, 1'b0);
    drain();

    // Back-pressure: fill with out_ready low, then random out_ready.
    hs0 = out_hs;
    out_ready = 1'b0;
    send_words(3, 0, 1, 1'b0);
    in_valid = 1'b1;
    in_data  = word_of(1, 3);
    in_tag   = 4'h3;
    #1;
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    step();
    step();
    send_words(7, 3, 1, 1'b1);
    drain();
    check("bp_out_count", 64'(out_hs - hs0), 64'(10));

    // Flush with a simultaneous input.
    out_ready = 1'b0;
    send_words(3, 10, 1, 1'b0);
    hs0 = out_hs;
    in_valid = 1'b1;
    in_data  = word_of(1, 13);
    in_tag   = 4'hD;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_in_ready",  64'(in_ready), 64'(1));
    out_ready = 1'b1;
    repeat (6) step();
    check("flush_no_output", 64'(out_hs - hs0), 64'(0));
    known_vec(4'b0000, 4'b1000, 4'h7, "post_flush");

    // Asynchronous reset mid-stream.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = word_of(1, 20 + i);
      in_tag   = 4'(i);
      step();
    end
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   64'(out_valid), 64'(0));
    check("mid_rst_outputs", 64'({out_data, out_zero, out_tag}), 64'(0));
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    hs0 = out_hs;
    repeat (5) step();
    check("post_rst_silent", 64'(out_hs - hs0), 64'(0));
    known_vec(4'b0000, 4'b1000, 4'h9, "post_rst");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
